// File: rtl/csr_sequencer_if.sv
// CSR file port bundle between the Zicsr sequencer (master)
// and the CSR file (slave); rdata/invalid are combinational.
interface csr_sequencer_if;
  logic [11:0] csr_addr;
  logic        csr_read;
  logic        csr_write;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        csr_invalid;

  modport master (
    output csr_addr,
    output csr_read,
    output csr_write,
    output csr_wdata,
    input  csr_rdata,
    input  csr_invalid
  );

  modport slave (
    input  csr_addr,
    input  csr_read,
    input  csr_write,
    input  csr_wdata,
    output csr_rdata,
    output csr_invalid
  );
endinterface

// File: rtl/csr_sequencer.sv
// Zicsr read/check/write sequencer driving the CSR file port.
// Optional CSR_SEQ_WRITE_SKIP_EN: skip set/clear writes that change nothing.
module csr_sequencer (
  input  logic                 phi2,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [2:0]           funct3,
  input  logic [11:0]          csr_addr_in,
  input  logic [63:0]          rs1_val,
  input  logic [4:0]           src_idx,
  input  logic                 rd_zero,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic                 rd_we,
  output logic [63:0]          rd_data,
  csr_sequencer_if.master      csr
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [63:0] src_q;
  logic [63:0] old_q;
  logic [63:0] wdata_q;
  logic        rdz_q;
  logic        wr_q;
  logic        ill_q;

  logic        legal;
  logic        ill_d;
  logic        skip;
  logic [63:0] wdata_d;

  assign legal = (op_q != 2'b00);

  // Writing a read-only CSR (addr[11:10]==11) is illegal
  assign ill_d = !legal
               | csr.csr_invalid
               | (wr_q & (addr_q[11:10] == 2'b11));

  always_comb begin
    wdata_d = wdata_q;
    unique case (op_q)
      2'b01:   wdata_d = src_q;
      2'b10:   wdata_d = csr.csr_rdata | src_q;
      2'b11:   wdata_d = csr.csr_rdata & ~src_q;
      default: wdata_d = wdata_q;
    endcase
  end

`ifdef CSR_SEQ_WRITE_SKIP_EN
  assign skip = op_q[1] & (wdata_d == csr.csr_rdata);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = READ;
      READ:  state_d = (wr_q & !ill_d & !skip)
                       ? WRITE : RESP;
      WRITE: state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge phi2) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      addr_q  <= '0;
      src_q   <= '0;
      old_q   <= '0;
      wdata_q <= '0;
      rdz_q   <= 1'b0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start && !flush) begin
        op_q   <= funct3[1:0];
        addr_q <= csr_addr_in;
        src_q  <= funct3[2] ? {59'd0, src_idx}
                            : rs1_val;
        rdz_q  <= rd_zero;
        wr_q   <= (funct3[1:0] == 2'b01)
                | (funct3[1] & (src_idx != 5'd0));
      end
      if (state_q == READ) begin
        old_q   <= csr.csr_rdata;
        ill_q   <= ill_d;
        wdata_q <= wdata_d;
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign csr.csr_read  = (state_q == READ) & legal & !flush;
  assign csr.csr_write = (state_q == WRITE) & !flush;
  assign done          = (state_q == RESP) & !flush;
  assign illegal       = done & ill_q;
  assign rd_we         = done & !ill_q & !rdz_q;
  assign rd_data       = old_q;
  assign csr.csr_addr  = addr_q;
  assign csr.csr_wdata = wdata_q;

endmodule

// File: tb/tb_csr_sequencer.sv
// Scoreboard bench for csr_sequencer with a behavioural CSR file.
// Expected responses are queued at issue and checked on done.
module tb_csr_sequencer;

  logic        phi2 = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [11:0] csr_addr_in;
  logic [63:0] rs1_val;
  logic [4:0]  src_idx;
  logic        rd_zero;
  logic        busy;
  logic        done;
  logic        illegal;
  logic        rd_we;
  logic [63:0] rd_data;
  logic        inv;

  csr_sequencer_if bus ();

  csr_sequencer dut (
    .phi2        (phi2),
    .rst         (rst),
    .start       (start),
    .flush       (flush),
    .funct3      (funct3),
    .csr_addr_in (csr_addr_in),
    .rs1_val     (rs1_val),
    .src_idx     (src_idx),
    .rd_zero     (rd_zero),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .rd_we       (rd_we),
    .rd_data     (rd_data),
    .csr         (bus)
  );

  always #5 phi2 = ~phi2;

  logic [63:0] mem [4096];
  assign bus.csr_rdata   = mem[bus.csr_addr];
  assign bus.csr_invalid = inv;

  int cyc = 0;
  always @(posedge phi2) begin
    cyc = cyc + 1;
    if (bus.csr_write) mem[bus.csr_addr] = bus.csr_wdata;
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    logic        ill;
    logic        we;
    logic [63:0] rd;
    int          nwr;
    logic [63:0] wd;
    int          nrd;
    int          lat;
    int          s;
    int          wbase;
    int          rbase;
  } exp_t;

  exp_t q[$];
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [63:0] last_wd = '0;

  always @(negedge phi2) begin
    if (bus.csr_write) begin
      wr_cnt  = wr_cnt + 1;
      last_wd = bus.csr_wdata;
    end
    if (bus.csr_read) rd_cnt = rd_cnt + 1;
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("illegal", 64'(illegal), 64'(e.ill));
        chk("rd_we", 64'(rd_we), 64'(e.we));
        chk("rd_data", rd_data, e.rd);
        chk("latency", 64'(cyc - e.s), 64'(e.lat));
        chk("writes", 64'(wr_cnt - e.wbase), 64'(e.nwr));
        chk("reads", 64'(rd_cnt - e.rbase), 64'(e.nrd));
        if (e.nwr != 0) chk("wdata", last_wd, e.wd);
      end
    end
  end

  task automatic issue(
    input logic [2:0]  f3,
    input logic [11:0] a,
    input logic [63:0] r,
    input logic [4:0]  ix,
    input logic        rz,
    input logic        iv,
    input logic        e_ill,
    input logic        e_we,
    input logic [63:0] e_rd,
    input int          e_nwr,
    input logic [63:0] e_wd,
    input int          e_nrd,
    input int          e_lat);
    exp_t e;
    @(negedge phi2);
    funct3      = f3;
    csr_addr_in = a;
    rs1_val     = r;
    src_idx     = ix;
    rd_zero     = rz;
    inv         = iv;
    start       = 1'b1;
    e.ill   = e_ill;
    e.we    = e_we;
    e.rd    = e_rd;
    e.nwr   = e_nwr;
    e.wd    = e_wd;
    e.nrd   = e_nrd;
    e.lat   = e_lat;
    e.s     = cyc;
    e.wbase = wr_cnt;
    e.rbase = rd_cnt;
    q.push_back(e);
    @(negedge phi2);
    start = 1'b0;
    for (int i = 0; i < 10 && !done; i++)
      @(negedge phi2);
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL timeout: got no done expected done");
      q.delete();
    end
    inv = 1'b0;
  endtask

  initial begin
    int s;
    int wb;
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    funct3 = 3'b000;
    csr_addr_in = '0;
    rs1_val = '0;
    src_idx = '0;
    rd_zero = 1'b0;
    inv = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h340] = 64'h1234;
    mem[12'h300] = 64'hA00;
    mem[12'h304] = 64'hAA;
    mem[12'hF11] = 64'h5A;
    mem[12'h305] = 64'h100;
    mem[12'hC00] = 64'h1111;
    mem[12'h140] = 64'h55;

    repeat (3) @(negedge phi2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_rd_we", 64'(rd_we), 64'd0);
    chk("rst_read", 64'(bus.csr_read), 64'd0);
    chk("rst_write", 64'(bus.csr_write), 64'd0);
    chk("rst_addr", 64'(bus.csr_addr), 64'd0);
    chk("rst_wdata", bus.csr_wdata, 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    rst = 1'b0;

    // f3 addr rs1 idx rdz inv | ill we rd nwr wd nrd lat
    issue(3'b001, 12'h340, 64'hDEAD, 5'd5, 0, 0,
          0, 1, 64'h1234, 1, 64'hDEAD, 1, 3);
    issue(3'b010, 12'h300, 64'h0, 5'd0, 0, 0,
          0, 1, 64'hA00, 0, 64'h0, 1, 2);
    issue(3'b111, 12'h304, 64'h0, 5'd8, 0, 0,
          0, 1, 64'hAA, 1, 64'hA2, 1, 3);
    issue(3'b001, 12'hF11, 64'h5, 5'd3, 0, 0,
          1, 0, 64'h5A, 0, 64'h0, 1, 2);
    issue(3'b010, 12'h300, 64'h2, 5'd2, 0, 1,
          1, 0, 64'hA00, 0, 64'h0, 1, 2);
    issue(3'b100, 12'h340, 64'h1, 5'd1, 0, 0,
          1, 0, 64'hDEAD, 0, 64'h0, 0, 2);
    @(negedge phi2);
    mem[12'h304] = 64'hFF;
`ifdef CSR_SEQ_WRITE_SKIP_EN
    issue(3'b010, 12'h304, 64'h0F, 5'd1, 0, 0,
          0, 1, 64'hFF, 0, 64'h0, 1, 2);
`else
    issue(3'b010, 12'h304, 64'h0F, 5'd1, 0, 0,
          0, 1, 64'hFF, 1, 64'hFF, 1, 3);
`endif
    issue(3'b011, 12'h340, 64'hD, 5'd7, 1, 0,
          0, 0, 64'hDEAD, 1, 64'hDEA0, 1, 3);
    issue(3'b110, 12'h305, 64'h0, 5'h10, 0, 0,
          0, 1, 64'h100, 1, 64'h110, 1, 3);
    issue(3'b101, 12'h340, 64'h0, 5'd0, 0, 0,
          0, 1, 64'hDEA0, 1, 64'h0, 1, 3);
    issue(3'b010, 12'hC00, 64'h0, 5'd0, 0, 0,
          0, 1, 64'h1111, 0, 64'h0, 1, 2);
    issue(3'b010, 12'hC00, 64'h3, 5'd3, 0, 0,
          1, 0, 64'h1111, 0, 64'h0, 1, 2);

    // flush during WRITE of CSRRW 0x140
    @(negedge phi2);
    funct3 = 3'b001;
    csr_addr_in = 12'h140;
    rs1_val = 64'hBEEF;
    src_idx = 5'd4;
    rd_zero = 1'b0;
    start = 1'b1;
    s = cyc;
    wb = wr_cnt;
    @(negedge phi2);
    start = 1'b0;
    @(negedge phi2);
    chk("pre_flush_write", 64'(bus.csr_write), 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_write", 64'(bus.csr_write), 64'd0);
    @(negedge phi2);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_cycles", 64'(cyc - s), 64'd3);
    repeat (3) @(negedge phi2);
    chk("flush_sscratch", mem[12'h140], 64'h55);
    chk("flush_nwr", 64'(wr_cnt - wb), 64'd0);

    // reset during READ
    @(negedge phi2);
    funct3 = 3'b001;
    csr_addr_in = 12'h340;
    rs1_val = 64'h77;
    src_idx = 5'd1;
    start = 1'b1;
    wb = wr_cnt;
    @(negedge phi2);
    start = 1'b0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge phi2);
    rst = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge phi2);
    chk("rst_mid_mem", mem[12'h340], 64'h0);
    chk("rst_mid_nwr", 64'(wr_cnt - wb), 64'd0);

    issue(3'b001, 12'h140, 64'h99, 5'd9, 0, 0,
          0, 1, 64'h55, 1, 64'h99, 1, 3);
    repeat (2) @(negedge phi2);
    chk("final_sscratch", mem[12'h140], 64'h99);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
